// File: rtl/rs_station_param.sv
// ---------------------------------------------------------------------------
// rs_station_param
//
// Parametrised reservation station for ALU/branch ops. Dispatched ops wait
// here until both source operands carry tag 0 ("value present"). Operands are
// woken by results broadcast on NUM_CDB common data buses. One ready op per
// cycle is handed to the ALU through a registered valid/ready output stage.
// A ROB flush (mispredict) empties the station.
//
// Build option:
//   RS_OLDEST_FIRST_EN  defined   -> issue picks the oldest ready entry
//                                    (per-entry age counters are built)
//                       undefined -> issue picks the lowest-index ready entry
//
// Ports:
//   clk, rst (sync, active-low), rdy (global enable), flush (ROB mispredict)
//   in_*          dispatch payload, qualified by in_flag
//   cdb_*         packed broadcast channels, channel k at slice k
//   exe_ready     ALU accepts the presented op
//   exe_*         presented op, qualified by exe_flag
//   free_cnt      registered count of free entries
//   rs_nex_ava    at least one entry will be free next cycle
// ---------------------------------------------------------------------------
module rs_station_param #(
    parameter int RS_DEPTH = 8,
    parameter int ROB_BW   = 4,
    parameter int NUM_CDB  = 2,
    parameter int CODE_W   = 6,
    localparam int RS_BW   = $clog2(RS_DEPTH),
    localparam int CNT_W   = RS_BW + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      in_flag,
    input  logic [31:0]               in_V1,
    input  logic [31:0]               in_V2,
    input  logic [ROB_BW-1:0]         in_Q1,
    input  logic [ROB_BW-1:0]         in_Q2,
    input  logic [31:0]               in_A,
    input  logic [CODE_W-1:0]         in_code,
    input  logic [ROB_BW-1:0]         in_rob_id,
    input  logic [31:0]               in_pc,
    input  logic [NUM_CDB-1:0]        cdb_flag,
    input  logic [NUM_CDB*ROB_BW-1:0] cdb_rob_id,
    input  logic [NUM_CDB*32-1:0]     cdb_val,
    input  logic                      exe_ready,
    output logic                      exe_flag,
    output logic [31:0]               exe_V1,
    output logic [31:0]               exe_V2,
    output logic [31:0]               exe_A,
    output logic [31:0]               exe_pc,
    output logic [CODE_W-1:0]         exe_code,
    output logic [ROB_BW-1:0]         exe_rob_id,
    output logic [CNT_W-1:0]          free_cnt,
    output logic                      rs_nex_ava
);

    // Entry storage
    logic [RS_DEPTH-1:0] busy_q, busy_d;
    logic [ROB_BW-1:0]   q1_q   [RS_DEPTH];
    logic [ROB_BW-1:0]   q1_d   [RS_DEPTH];
    logic [ROB_BW-1:0]   q2_q   [RS_DEPTH];
    logic [ROB_BW-1:0]   q2_d   [RS_DEPTH];
    logic [31:0]         v1_q   [RS_DEPTH];
    logic [31:0]         v1_d   [RS_DEPTH];
    logic [31:0]         v2_q   [RS_DEPTH];
    logic [31:0]         v2_d   [RS_DEPTH];
    logic [31:0]         a_q    [RS_DEPTH];
    logic [31:0]         a_d    [RS_DEPTH];
    logic [31:0]         pc_q   [RS_DEPTH];
    logic [31:0]         pc_d   [RS_DEPTH];
    logic [CODE_W-1:0]   code_q [RS_DEPTH];
    logic [CODE_W-1:0]   code_d [RS_DEPTH];
    logic [ROB_BW-1:0]   rob_q  [RS_DEPTH];
    logic [ROB_BW-1:0]   rob_d  [RS_DEPTH];
`ifdef RS_OLDEST_FIRST_EN
    logic [RS_BW-1:0]    age_q  [RS_DEPTH];
    logic [RS_BW-1:0]    age_d  [RS_DEPTH];
    logic                sel_found;
    logic [RS_BW-1:0]    best_age;
`endif

    // Output stage
    logic                exe_flag_q, exe_flag_d;
    logic [31:0]         exe_v1_q, exe_v1_d;
    logic [31:0]         exe_v2_q, exe_v2_d;
    logic [31:0]         exe_a_q, exe_a_d;
    logic [31:0]         exe_pc_q, exe_pc_d;
    logic [CODE_W-1:0]   exe_code_q, exe_code_d;
    logic [ROB_BW-1:0]   exe_rob_q, exe_rob_d;
    logic [CNT_W-1:0]    free_cnt_q, free_cnt_d;

    // Wakeup / selection helpers
    logic [32:0]         wake1 [RS_DEPTH];   // {hit, value}
    logic [32:0]         wake2 [RS_DEPTH];
    logic [32:0]         cap1, cap2;
    logic [RS_DEPTH-1:0] ready_vec;
    logic                any_ready;
    logic                issue_fire;
    logic [RS_BW-1:0]    sel_idx;
    logic [RS_BW-1:0]    disp_idx;

    // Search all broadcast channels for a tag. Scanning from the top down
    // lets the lowest-numbered matching channel overwrite the result last.
    // Tag 0 means "already has its value" and never matches.
    function automatic logic [32:0] cdb_lookup(
        input logic [ROB_BW-1:0]         tag,
        input logic [NUM_CDB-1:0]        flags,
        input logic [NUM_CDB*ROB_BW-1:0] ids,
        input logic [NUM_CDB*32-1:0]     vals
    );
        logic [32:0] res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (tag != '0 && flags[k] && ids[k*ROB_BW +: ROB_BW] == tag) begin
                res = {1'b1, vals[k*32 +: 32]};
            end
        end
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
            assign wake1[gi]     = cdb_lookup(q1_q[gi], cdb_flag, cdb_rob_id, cdb_val);
            assign wake2[gi]     = cdb_lookup(q2_q[gi], cdb_flag, cdb_rob_id, cdb_val);
            assign ready_vec[gi] = busy_q[gi] && (q1_q[gi] == '0) && (q2_q[gi] == '0);
        end
    endgenerate

    // Same-cycle capture for the op being dispatched, so a result broadcast
    // in the dispatch cycle is not missed.
    assign cap1 = cdb_lookup(in_Q1, cdb_flag, cdb_rob_id, cdb_val);
    assign cap2 = cdb_lookup(in_Q2, cdb_flag, cdb_rob_id, cdb_val);

    always_comb begin : sel_logic
        any_ready = |ready_vec;
        sel_idx   = '0;
        disp_idx  = '0;
`ifdef RS_OLDEST_FIRST_EN
        // Ages of live entries are distinct, so strict '>' gives a unique pick.
        sel_found = 1'b0;
        best_age  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ready_vec[i] && (!sel_found || age_q[i] > best_age)) begin
                sel_found = 1'b1;
                best_age  = age_q[i];
                sel_idx   = RS_BW'(i);
            end
        end
`else
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_idx = RS_BW'(i);
            end
        end
`endif
        // Dispatch uses registered busy bits: a slot freed by this cycle's
        // issue only becomes reusable next cycle.
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                disp_idx = RS_BW'(i);
            end
        end
    end

    assign issue_fire = any_ready && (!exe_flag_q || exe_ready);

    always_comb begin : next_state
        busy_d     = busy_q;
        free_cnt_d = free_cnt_q;
        exe_flag_d = exe_flag_q;
        exe_v1_d   = exe_v1_q;
        exe_v2_d   = exe_v2_q;
        exe_a_d    = exe_a_q;
        exe_pc_d   = exe_pc_q;
        exe_code_d = exe_code_q;
        exe_rob_d  = exe_rob_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            q1_d[i]   = q1_q[i];
            q2_d[i]   = q2_q[i];
            v1_d[i]   = v1_q[i];
            v2_d[i]   = v2_q[i];
            a_d[i]    = a_q[i];
            pc_d[i]   = pc_q[i];
            code_d[i] = code_q[i];
            rob_d[i]  = rob_q[i];
`ifdef RS_OLDEST_FIRST_EN
            age_d[i]  = age_q[i];
`endif
        end

        if (rdy) begin
            if (flush) begin
                busy_d     = '0;
                exe_flag_d = 1'b0;
                free_cnt_d = CNT_W'(RS_DEPTH);
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (busy_q[i] && wake1[i][32]) begin
                        v1_d[i] = wake1[i][31:0];
                        q1_d[i] = '0;
                    end
                    if (busy_q[i] && wake2[i][32]) begin
                        v2_d[i] = wake2[i][31:0];
                        q2_d[i] = '0;
                    end
`ifdef RS_OLDEST_FIRST_EN
                    if (in_flag && busy_q[i]) begin
                        age_d[i] = age_q[i] + RS_BW'(1);
                    end
`endif
                end

                if (issue_fire) begin
                    busy_d[sel_idx] = 1'b0;
                    exe_flag_d      = 1'b1;
                    exe_v1_d        = v1_q[sel_idx];
                    exe_v2_d        = v2_q[sel_idx];
                    exe_a_d         = a_q[sel_idx];
                    exe_pc_d        = pc_q[sel_idx];
                    exe_code_d      = code_q[sel_idx];
                    exe_rob_d       = rob_q[sel_idx];
                end else if (exe_ready) begin
                    exe_flag_d = 1'b0;
                end

                if (in_flag) begin
                    busy_d[disp_idx] = 1'b1;
                    q1_d[disp_idx]   = cap1[32] ? '0 : in_Q1;
                    v1_d[disp_idx]   = cap1[32] ? cap1[31:0] : in_V1;
                    q2_d[disp_idx]   = cap2[32] ? '0 : in_Q2;
                    v2_d[disp_idx]   = cap2[32] ? cap2[31:0] : in_V2;
                    a_d[disp_idx]    = in_A;
                    pc_d[disp_idx]   = in_pc;
                    code_d[disp_idx] = in_code;
                    rob_d[disp_idx]  = in_rob_id;
`ifdef RS_OLDEST_FIRST_EN
                    age_d[disp_idx]  = '0;
`endif
                end

                free_cnt_d = free_cnt_q - CNT_W'(in_flag) + CNT_W'(issue_fire);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q     <= '0;
            exe_flag_q <= 1'b0;
            exe_v1_q   <= '0;
            exe_v2_q   <= '0;
            exe_a_q    <= '0;
            exe_pc_q   <= '0;
            exe_code_q <= '0;
            exe_rob_q  <= '0;
            free_cnt_q <= CNT_W'(RS_DEPTH);
        end else begin
            busy_q     <= busy_d;
            exe_flag_q <= exe_flag_d;
            exe_v1_q   <= exe_v1_d;
            exe_v2_q   <= exe_v2_d;
            exe_a_q    <= exe_a_d;
            exe_pc_q   <= exe_pc_d;
            exe_code_q <= exe_code_d;
            exe_rob_q  <= exe_rob_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    // Entry payload needs no reset: it is only observed while busy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            q1_q[i]   <= q1_d[i];
            q2_q[i]   <= q2_d[i];
            v1_q[i]   <= v1_d[i];
            v2_q[i]   <= v2_d[i];
            a_q[i]    <= a_d[i];
            pc_q[i]   <= pc_d[i];
            code_q[i] <= code_d[i];
            rob_q[i]  <= rob_d[i];
`ifdef RS_OLDEST_FIRST_EN
            age_q[i]  <= age_d[i];
`endif
        end
    end

    // Dispatching into a full station is a caller protocol violation.
    always_ff @(posedge clk) begin
        if (rst && rdy && !flush && in_flag) begin
            assert (free_cnt_q != '0);
        end
    end

    assign exe_flag   = exe_flag_q;
    assign exe_V1     = exe_v1_q;
    assign exe_V2     = exe_v2_q;
    assign exe_A      = exe_a_q;
    assign exe_pc     = exe_pc_q;
    assign exe_code   = exe_code_q;
    assign exe_rob_id = exe_rob_q;
    assign free_cnt   = free_cnt_q;
    assign rs_nex_ava = (free_cnt_d != '0);

endmodule

// File: tb/tb_rs_station_param.sv
// ---------------------------------------------------------------------------
// tb_rs_station_param
//
// Scoreboard bench. The driver applies directed and random stimulus and runs
// a behavioural model of the station (a set of waiting ops, picked by
// dispatch order or slot number). Every issue the model predicts is queued;
// an independent monitor pops the queue whenever the DUT presents a new op,
// and checks held ops stay stable while the ALU stalls.
// ---------------------------------------------------------------------------
module tb_rs_station_param;

    logic        clk;
    logic        rst, rdy, flush, in_flag;
    logic [31:0] in_V1, in_V2, in_A, in_pc;
    logic [3:0]  in_Q1, in_Q2, in_rob_id;
    logic [5:0]  in_code;
    logic [1:0]  cdb_flag;
    logic [7:0]  cdb_rob_id;
    logic [63:0] cdb_val;
    logic        exe_ready;
    logic        exe_flag;
    logic [31:0] exe_V1, exe_V2, exe_A, exe_pc;
    logic [5:0]  exe_code;
    logic [3:0]  exe_rob_id;
    logic [3:0]  free_cnt;
    logic        rs_nex_ava;

    rs_station_param dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_flag(in_flag),
        .in_V1(in_V1), .in_V2(in_V2), .in_Q1(in_Q1), .in_Q2(in_Q2),
        .in_A(in_A), .in_code(in_code), .in_rob_id(in_rob_id), .in_pc(in_pc),
        .cdb_flag(cdb_flag), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .exe_ready(exe_ready), .exe_flag(exe_flag),
        .exe_V1(exe_V1), .exe_V2(exe_V2), .exe_A(exe_A), .exe_pc(exe_pc),
        .exe_code(exe_code), .exe_rob_id(exe_rob_id),
        .free_cnt(free_cnt), .rs_nex_ava(rs_nex_ava)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, rdy, flush, in_flag, exe_ready;
        logic [31:0] v1, v2, a, pc;
        logic [3:0]  q1, q2, rob;
        logic [5:0]  code;
        logic [1:0]  cdb_flag;
        logic [7:0]  cdb_id;
        logic [63:0] cdb_val;
    } stim_t;

    typedef struct packed {
        logic [31:0] v1, v2, a, pc;
        logic [5:0]  code;
        logic [3:0]  rob;
    } exe_t;

    typedef struct {
        logic [31:0] v1, v2, a, pc;
        logic [3:0]  q1, q2, rob;
        logic [5:0]  code;
        int          seq;
    } op_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exe_t exp_q[$];

    // Model state
    bit   m_busy [8];
    op_t  m_op   [8];
    bit   m_exe_valid;
    int   m_seq = 0;
    bit   model_valid = 0;
    bit   exp_ava;
    bit   last_ava = 0;
    bit   pend_valid;
    exe_t pend;

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < 8; i++) if (!m_busy[i]) n++;
        return n;
    endfunction

    // Lowest-numbered channel carrying the tag supplies the value.
    function automatic bit cdb_match(input stim_t s, input logic [3:0] tag,
                                     output logic [31:0] val);
        val = '0;
        if (tag == 4'd0) return 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (s.cdb_flag[k] && s.cdb_id[k*4 +: 4] == tag) begin
                val = s.cdb_val[k*32 +: 32];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_step(input stim_t s);
        int          pick, slot, nfree;
        bit          issue;
        logic [31:0] cv;
        op_t         o;
        pend_valid = 1'b0;
        if (!s.rst) begin
            for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
            m_exe_valid = 1'b0;
            model_valid = 1'b1;
            exp_ava     = 1'b1;
            return;
        end
        nfree = m_free();
        if (!s.rdy) begin
            exp_ava = (nfree >= 1);
            return;
        end
        if (s.flush) begin
            for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
            m_exe_valid = 1'b0;
            exp_ava     = 1'b1;
            return;
        end
        pick = -1;
        for (int i = 0; i < 8; i++) begin
            if (m_busy[i] && m_op[i].q1 == 4'd0 && m_op[i].q2 == 4'd0) begin
`ifdef RS_OLDEST_FIRST_EN
                if (pick < 0 || m_op[i].seq < m_op[pick].seq) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        issue = (pick >= 0) && (!m_exe_valid || s.exe_ready);
        slot = -1;
        for (int i = 0; i < 8; i++) if (!m_busy[i] && slot < 0) slot = i;
        if (issue) begin
            pend.v1   = m_op[pick].v1;
            pend.v2   = m_op[pick].v2;
            pend.a    = m_op[pick].a;
            pend.pc   = m_op[pick].pc;
            pend.code = m_op[pick].code;
            pend.rob  = m_op[pick].rob;
            pend_valid   = 1'b1;
            m_busy[pick] = 1'b0;
            m_exe_valid  = 1'b1;
        end else if (s.exe_ready) begin
            m_exe_valid = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            if (m_busy[i]) begin
                if (cdb_match(s, m_op[i].q1, cv)) begin m_op[i].v1 = cv; m_op[i].q1 = 4'd0; end
                if (cdb_match(s, m_op[i].q2, cv)) begin m_op[i].v2 = cv; m_op[i].q2 = 4'd0; end
            end
        end
        if (s.in_flag && slot >= 0) begin
            o.v1 = s.v1; o.q1 = s.q1;
            o.v2 = s.v2; o.q2 = s.q2;
            if (cdb_match(s, s.q1, cv)) begin o.v1 = cv; o.q1 = 4'd0; end
            if (cdb_match(s, s.q2, cv)) begin o.v2 = cv; o.q2 = 4'd0; end
            o.a = s.a; o.pc = s.pc; o.code = s.code; o.rob = s.rob;
            o.seq = m_seq;
            m_seq++;
            m_op[slot]   = o;
            m_busy[slot] = 1'b1;
        end
        exp_ava = ((nfree - (s.in_flag ? 1 : 0) + (issue ? 1 : 0)) >= 1);
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        s.rdy = 1'b1;
        s.exe_ready = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = idle_stim();
        s.rdy       = ($urandom_range(0, 99) >= 10);
        s.flush     = ($urandom_range(0, 99) < 2);
        s.exe_ready = ($urandom_range(0, 99) < 70);
        s.in_flag   = ($urandom_range(0, 99) < 45) && last_ava;
        s.v1   = $urandom;
        s.v2   = $urandom;
        s.a    = $urandom;
        s.pc   = $urandom;
        s.code = 6'($urandom_range(0, 63));
        s.rob  = 4'($urandom_range(1, 15));
        s.q1   = ($urandom_range(0, 99) < 50) ? 4'd0 : 4'($urandom_range(1, 7));
        s.q2   = ($urandom_range(0, 99) < 50) ? 4'd0 : 4'($urandom_range(1, 7));
        s.cdb_flag = 2'($urandom_range(0, 3));
        s.cdb_id   = {4'($urandom_range(1, 7)), 4'($urandom_range(1, 7))};
        if ($urandom_range(0, 7) == 0) s.cdb_id[7:4] = s.cdb_id[3:0];
        s.cdb_val  = {$urandom, $urandom};
        return s;
    endfunction

    task automatic run(input stim_t s);
        int exp_free;
        @(negedge clk);
        if (model_valid) begin
            exp_free = m_free();
            n_cmp++;
            if (int'(free_cnt) != exp_free) begin
                n_bad++;
                $display("FAIL free_cnt: got %0d expected %0d at %0t", free_cnt, exp_free, $time);
            end
        end
        rst = s.rst; rdy = s.rdy; flush = s.flush; in_flag = s.in_flag;
        in_V1 = s.v1; in_V2 = s.v2; in_Q1 = s.q1; in_Q2 = s.q2;
        in_A = s.a; in_pc = s.pc; in_code = s.code; in_rob_id = s.rob;
        cdb_flag = s.cdb_flag; cdb_rob_id = s.cdb_id; cdb_val = s.cdb_val;
        exe_ready = s.exe_ready;
        model_step(s);
        last_ava = exp_ava;
        #1;
        if (s.rst) begin
            n_cmp++;
            if (rs_nex_ava !== exp_ava) begin
                n_bad++;
                $display("FAIL rs_nex_ava: got %0b expected %0b at %0t", rs_nex_ava, exp_ava, $time);
            end
        end
        @(posedge clk);
        #1;
        if (pend_valid) exp_q.push_back(pend);
    endtask

    // Monitor: what the DUT shows at a negedge reflects the previous posedge.
    initial begin : monitor
        exe_t cur, got;
        bit   presented = 1'b0;
        bit   armed = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            #3;
            got = {exe_V1, exe_V2, exe_A, exe_pc, exe_code, exe_rob_id};
            if (armed) begin
                n_cmp++;
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    presented = 1'b1;
                    $display("issue rob=%0d V1=%h V2=%h A=%h pc=%h code=%0d",
                             cur.rob, cur.v1, cur.v2, cur.a, cur.pc, cur.code);
                    if (exe_flag !== 1'b1 || got !== cur) begin
                        n_bad++;
                        $display("FAIL issue: got flag=%0b rob=%0d V1=%h V2=%h A=%h pc=%h code=%0d expected rob=%0d V1=%h V2=%h A=%h pc=%h code=%0d",
                                 exe_flag, got.rob, got.v1, got.v2, got.a, got.pc, got.code,
                                 cur.rob, cur.v1, cur.v2, cur.a, cur.pc, cur.code);
                    end
                end else if (presented) begin
                    if (exe_flag !== 1'b1 || got !== cur) begin
                        n_bad++;
                        $display("FAIL hold: got flag=%0b rob=%0d V1=%h expected flag=1 rob=%0d V1=%h",
                                 exe_flag, got.rob, got.v1, cur.rob, cur.v1);
                    end
                end else begin
                    if (exe_flag !== 1'b0) begin
                        n_bad++;
                        $display("FAIL idle: got exe_flag=%0b rob=%0d expected exe_flag=0",
                                 exe_flag, exe_rob_id);
                    end
                end
            end
            if (rst === 1'b0) armed = 1'b1;
            if (rst === 1'b0 || (rdy && flush) || (rdy && exe_ready && presented))
                presented = 1'b0;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        stim_t s;
        rst = 1'b0; rdy = 1'b0; flush = 1'b0; in_flag = 1'b0;
        in_V1 = '0; in_V2 = '0; in_Q1 = '0; in_Q2 = '0; in_A = '0; in_pc = '0;
        in_code = '0; in_rob_id = '0; cdb_flag = '0; cdb_rob_id = '0; cdb_val = '0;
        exe_ready = 1'b0;

        // Reset
        s = idle_stim(); s.rst = 1'b0;
        run(s); run(s);
        n_cmp++;
        if (exe_flag !== 1'b0 || {exe_V1, exe_V2, exe_A, exe_pc, exe_code, exe_rob_id} !== '0) begin
            n_bad++;
            $display("FAIL reset_exe: got flag=%0b V1=%h A=%h rob=%0d expected all zero",
                     exe_flag, exe_V1, exe_A, exe_rob_id);
        end

        // Ready op straight through
        s = idle_stim(); s.in_flag = 1'b1; s.rob = 4'd3; s.a = 32'd5;
        s.v1 = 32'h11; s.v2 = 32'h22; s.pc = 32'h40; s.code = 6'd1;
        run(s);
        repeat (3) run(idle_stim());

        // Dispatch-time capture from channel 0
        s = idle_stim(); s.in_flag = 1'b1; s.q1 = 4'd2; s.rob = 4'd4; s.v1 = 32'hDEAD;
        s.cdb_flag = 2'b01; s.cdb_id = 8'h02; s.cdb_val = 64'h0000_0000_0000_1234;
        run(s);
        repeat (3) run(idle_stim());

        // Fill all entries waiting on tag 7, then wake them on channel 1
        for (int i = 0; i < 8; i++) begin
            s = idle_stim(); s.in_flag = 1'b1; s.q1 = 4'd7; s.rob = 4'(i + 1);
            s.a = 32'(i); s.pc = 32'h100 + 32'(i * 4); s.code = 6'(i);
            run(s);
        end
        s = idle_stim(); s.cdb_flag = 2'b10; s.cdb_id = 8'h70; s.cdb_val = 64'hABCD_0123_0000_0000;
        run(s);
        repeat (10) run(idle_stim());

        // ALU stall with two ready entries
        s = idle_stim(); s.exe_ready = 1'b0; s.in_flag = 1'b1; s.rob = 4'd9; s.a = 32'h90;
        run(s);
        s.rob = 4'd10; s.a = 32'hA0;
        run(s);
        s = idle_stim(); s.exe_ready = 1'b0;
        repeat (4) run(s);
        repeat (4) run(idle_stim());

        // Flush with a presented op and five waiting entries
        s = idle_stim(); s.exe_ready = 1'b0; s.in_flag = 1'b1; s.rob = 4'd11;
        run(s);
        for (int i = 0; i < 5; i++) begin
            s = idle_stim(); s.exe_ready = 1'b0; s.in_flag = 1'b1; s.q1 = 4'd9; s.rob = 4'(12 + i);
            run(s);
        end
        s = idle_stim(); s.exe_ready = 1'b0; s.flush = 1'b1;
        run(s);
        s = idle_stim(); s.cdb_flag = 2'b01; s.cdb_id = 8'h09; s.cdb_val = 64'h5555;
        repeat (3) run(s);
        repeat (3) run(idle_stim());

        // Random traffic, with one reset in the middle
        for (int i = 0; i < 2000; i++) begin
            s = rand_stim();
            if (i == 1000) s.rst = 1'b0;
            run(s);
        end

        s = idle_stim(); s.flush = 1'b1;
        run(s);
        repeat (5) run(idle_stim());
        @(negedge clk);
        #5;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unissued expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
